// File: rtl/crc_receiver.sv
// crc_receiver: receive side of the CRC-protected link.
// Two-stage pipeline: stage 1 captures the codeword, stage 2 checks the syndrome
// and presents the data field with an error flag. Also keeps saturating frame and
// error counters, plus a link-health FSM that raises alarm on repeated CRC failures.
module crc_receiver #(
    parameter int                BW           = 4,
    parameter int                CRC_BW       = 3,
    parameter logic [CRC_BW:0]   DIVISOR      = 4'b1011,
    parameter int                CNT_W        = 8,
    parameter int                ALARM_THRESH = 3,
    parameter int                CLEAR_THRESH = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [BW+CRC_BW-1:0] in_i,
    input  logic                 in_valid_i,
    input  logic                 clr_cnt_i,
    output logic [BW-1:0]        out_data_o,
    output logic                 out_valid_o,
    output logic                 crc_err_o,
    output logic [CNT_W-1:0]     frame_cnt_o,
    output logic [CNT_W-1:0]     err_cnt_o,
    output logic                 alarm_o
);

    localparam int CW = BW + CRC_BW;
    localparam int AW = $clog2(ALARM_THRESH + 1);
    localparam int GW = $clog2(CLEAR_THRESH + 1);
    localparam logic [AW-1:0] ALARM_T = AW'(ALARM_THRESH);
    localparam logic [GW-1:0] CLEAR_T = GW'(CLEAR_THRESH);

    typedef enum logic [1:0] {ST_OK, ST_SUSPECT, ST_ALARM} state_e;

    logic [CW-1:0]     cw_q;
    logic              v1_q;
    logic [CRC_BW:0]   rem;
    logic              syn_err;

    logic [BW-1:0]     out_data_q;
    logic              out_valid_q, crc_err_q, alarm_q;
    logic [CNT_W-1:0]  frame_cnt_q, err_cnt_q;

    state_e            state_q, state_d;
    logic [AW-1:0]     bad_run_q, bad_run_d, bad_inc;
    logic [GW-1:0]     good_run_q, good_run_d, good_inc;

    // Stage 1: capture the codeword; the data register holds on idle cycles.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            v1_q <= 1'b0;
            cw_q <= '0;
        end else begin
            v1_q <= in_valid_i;
            if (in_valid_i) cw_q <= in_i;
        end
    end

    // Syndrome: bit-serial GF(2) division of the codeword, MSB first.
    always_comb begin
        rem = '0;
        for (int i = CW - 1; i >= 0; i--) begin
            rem = {rem[CRC_BW-1:0], cw_q[i]};
            if (rem[CRC_BW]) rem = rem ^ DIVISOR;
        end
        syn_err = (rem[CRC_BW-1:0] != '0);
    end

    // Stage 2: present the checked frame and update saturating statistics.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            crc_err_q   <= 1'b0;
            out_data_q  <= '0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            out_valid_q <= v1_q;
            crc_err_q   <= v1_q & syn_err;
            if (v1_q) out_data_q <= cw_q[CW-1:CRC_BW];
            // A clear wins over the frame completing on the same edge.
            if (clr_cnt_i) begin
                frame_cnt_q <= '0;
                err_cnt_q   <= '0;
            end else if (v1_q) begin
                if (!(&frame_cnt_q)) frame_cnt_q <= frame_cnt_q + 1'b1;
                if (syn_err && !(&err_cnt_q)) err_cnt_q <= err_cnt_q + 1'b1;
            end
        end
    end

    // Link-health state register; alarm follows the next state so it lines up with out_valid.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_OK;
            bad_run_q  <= '0;
            good_run_q <= '0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bad_run_q  <= bad_run_d;
            good_run_q <= good_run_d;
            alarm_q    <= (state_d == ST_ALARM);
        end
    end

    // Link-health next state: only frames leaving stage 2 move the FSM.
    always_comb begin
        state_d    = state_q;
        bad_run_d  = bad_run_q;
        good_run_d = good_run_q;
        bad_inc    = bad_run_q + 1'b1;
        good_inc   = good_run_q + 1'b1;
        if (v1_q) begin
            case (state_q)
                // OK and SUSPECT share the bad-run logic; bad_run is 0 in OK,
                // so a threshold of 1 jumps straight to ALARM.
                ST_OK, ST_SUSPECT: begin
                    if (syn_err) begin
                        if (bad_inc == ALARM_T) begin
                            state_d    = ST_ALARM;
                            bad_run_d  = '0;
                            good_run_d = '0;
                        end else begin
                            state_d   = ST_SUSPECT;
                            bad_run_d = bad_inc;
                        end
                    end else begin
                        state_d   = ST_OK;
                        bad_run_d = '0;
                    end
                end
                ST_ALARM: begin
                    if (syn_err) begin
                        good_run_d = '0;
                    end else if (good_inc == CLEAR_T) begin
                        state_d    = ST_OK;
                        good_run_d = '0;
                    end else begin
                        good_run_d = good_inc;
                    end
                end
                default: begin
                    state_d    = ST_OK;
                    bad_run_d  = '0;
                    good_run_d = '0;
                end
            endcase
        end
    end

    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign crc_err_o   = crc_err_q;
    assign frame_cnt_o = frame_cnt_q;
    assign err_cnt_o   = err_cnt_q;
    assign alarm_o     = alarm_q;

endmodule

// File: tb/tb_crc_receiver.sv
// Scoreboard bench for crc_receiver: a frame-level reference model pushes the
// expected response of each completing frame; a monitor pops and compares.
module tb_crc_receiver;

    localparam int ATH = 3;
    localparam int CTH = 4;
    localparam int CNT_MAX = 15;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [6:0] in_i = '0;
    logic       in_valid_i = 1'b0;
    logic       clr_cnt_i = 1'b0;
    logic [3:0] out_data_o;
    logic       out_valid_o, crc_err_o, alarm_o;
    logic [3:0] frame_cnt_o, err_cnt_o;

    crc_receiver #(
        .BW(4), .CRC_BW(3), .DIVISOR(4'b1011), .CNT_W(4),
        .ALARM_THRESH(ATH), .CLEAR_THRESH(CTH)
    ) dut (
        .clk(clk), .rstn(rstn), .in_i(in_i), .in_valid_i(in_valid_i),
        .clr_cnt_i(clr_cnt_i), .out_data_o(out_data_o), .out_valid_o(out_valid_o),
        .crc_err_o(crc_err_o), .frame_cnt_o(frame_cnt_o), .err_cnt_o(err_cnt_o),
        .alarm_o(alarm_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] data;
        logic       err;
        int         fc;
        int         ec;
        logic       alarm;
    } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Remainder of a 7-bit codeword divided by x^3+x+1, by long division.
    function automatic logic [2:0] syn(input logic [6:0] cw);
        int r;
        r = int'(cw);
        for (int i = 6; i >= 3; i--)
            if (((r >> i) & 1) != 0) r = r ^ (32'b1011 << (i - 3));
        return 3'(r);
    endfunction

    function automatic logic [6:0] good_cw(input logic [3:0] d);
        logic [2:0] c;
        c = syn({d, 3'b000});
        return {d, c};
    endfunction

    // Reference model (frame level).
    logic       m_v = 1'b0;
    logic [6:0] m_cw = '0;
    int m_fc = 0, m_ec = 0, m_bad = 0, m_good = 0;
    int m_st = 0;  // 0 healthy, 1 suspect, 2 alarm
    logic m_alarm = 1'b0;

    always @(posedge clk) begin
        exp_t e;
        logic bad;
        if (!rstn) begin
            m_v = 1'b0; m_fc = 0; m_ec = 0; m_st = 0;
            m_bad = 0; m_good = 0; m_alarm = 1'b0;
        end else begin
            if (clr_cnt_i) begin
                m_fc = 0; m_ec = 0;
            end
            if (m_v) begin
                bad = (syn(m_cw) != 3'd0);
                if (!clr_cnt_i) begin
                    if (m_fc < CNT_MAX) m_fc++;
                    if (bad && m_ec < CNT_MAX) m_ec++;
                end
                if (bad) begin
                    if (m_st == 2) m_good = 0;
                    else begin
                        m_bad++;
                        if (m_bad == ATH) begin m_st = 2; m_bad = 0; m_good = 0; end
                        else m_st = 1;
                    end
                end else begin
                    if (m_st == 2) begin
                        m_good++;
                        if (m_good == CTH) begin m_st = 0; m_good = 0; end
                    end else begin
                        m_st = 0; m_bad = 0;
                    end
                end
                m_alarm = (m_st == 2);
                e.data = m_cw[6:3]; e.err = bad; e.fc = m_fc; e.ec = m_ec; e.alarm = m_alarm;
                q.push_back(e);
            end
            m_v = in_valid_i;
            m_cw = in_i;
        end
    end

    // Monitor: compare every presented frame; idle cycles check statistics.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid_o) begin
            if (q.size() == 0) chk("spurious_out_valid", 1, 0);
            else begin
                e = q.pop_front();
                chk("out_data", 32'(out_data_o), 32'(e.data));
                chk("crc_err", 32'(crc_err_o), 32'(e.err));
                chk("frame_cnt", 32'(frame_cnt_o), e.fc);
                chk("err_cnt", 32'(err_cnt_o), e.ec);
                chk("alarm", 32'(alarm_o), 32'(e.alarm));
            end
        end else begin
            if (q.size() != 0) begin
                chk("missing_out_valid", 0, 1);
                q.delete();
            end
            chk("idle_crc_err", 32'(crc_err_o), 0);
            chk("idle_frame_cnt", 32'(frame_cnt_o), m_fc);
            chk("idle_err_cnt", 32'(err_cnt_o), m_ec);
            chk("idle_alarm", 32'(alarm_o), 32'(m_alarm));
        end
    end

    task automatic cyc(input logic v, input logic [6:0] cw, input logic c);
        in_valid_i = v; in_i = cw; clr_cnt_i = c;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 7'h00, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        // Reset held with traffic present
        rstn = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b1, 7'h69, 1'b0);
        chk("rst_out_valid", 32'(out_valid_o), 0);
        chk("rst_out_data", 32'(out_data_o), 0);
        chk("rst_frame_cnt", 32'(frame_cnt_o), 0);
        chk("rst_err_cnt", 32'(err_cnt_o), 0);
        chk("rst_alarm", 32'(alarm_o), 0);
        in_valid_i = 1'b0;
        rstn = 1'b1;
        idle(3);

        // Good frames back to back, then a single error
        cyc(1'b1, 7'h69, 1'b0);
        cyc(1'b1, 7'h45, 1'b0);
        idle(3);
        cyc(1'b1, 7'h68, 1'b0);
        idle(3);
        cyc(1'b1, 7'h69, 1'b0);
        idle(2);

        // Alarm entry, good run interrupted, then exit
        for (int i = 0; i < 3; i++) cyc(1'b1, 7'h68, 1'b0);
        cyc(1'b1, 7'h69, 1'b0);
        cyc(1'b1, 7'h69, 1'b0);
        cyc(1'b1, 7'h68, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 7'h69, 1'b0);
        idle(3);

        // Saturation, then clear coincident with a completing frame
        for (int i = 0; i < 20; i++) cyc(1'b1, 7'h68, 1'b0);
        idle(3);
        cyc(1'b1, 7'h00, 1'b0);
        cyc(1'b0, 7'h00, 1'b1);
        idle(3);

        // Reset one cycle after a frame is accepted
        cyc(1'b1, 7'h45, 1'b0);
        rstn = 1'b0;
        cyc(1'b0, 7'h00, 1'b0);
        rstn = 1'b1;
        idle(3);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [3:0] d;
            logic [6:0] cw;
            d = 4'($urandom);
            cw = ($urandom_range(0, 1) == 0) ? good_cw(d) : 7'($urandom);
            rstn = ($urandom_range(0, 99) != 0);
            cyc(($urandom_range(0, 3) != 0), cw, ($urandom_range(0, 24) == 0));
        end
        rstn = 1'b1;
        idle(4);
        chk("queue_drained", 32'(q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
